// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
// Contents: state_t (arbiter FSM states), req_id_t (requester identity),
//           CNT_W (width of the response wait counter).
package mem_arb_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant selection
// Ports:
//   req   in  [1:0]  request lines, bit 0 = instruction side, bit 1 = data side
//   last  in         requester granted most recently
//   grant out        requester to grant (only meaningful when |req)
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output req_id_t    grant
);

    // Data wins when it is alone, or when both ask and inst went last.
    always_comb begin
        grant = REQ_I;
        if (req[1] && (!req[0] || last == REQ_I)) begin
            grant = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction and data requesters onto one memory port
// Parameters: ADDR_W address width, DATA_W data width, TIMEOUT response wait limit.
// Ports:
//   clk, reset (async, active low)
//   i_req/i_addr                         instruction-side read request
//   d_req/d_addr/d_we/d_wdata            data-side read/write request
//   i_req_ack/d_req_ack                  one-cycle request-accepted pulses
//   i_rsp/i_rdata, d_rsp/d_rdata         one-cycle responses with read data
//   err                                  one-cycle timeout pulse
//   mem_req/mem_addr/mem_we/mem_wdata    shared memory request
//   mem_req_ack/mem_rsp/mem_rdata        memory accept, response, read data
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              i_req_ack,
    output logic              d_req_ack,
    output logic              i_rsp,
    output logic              d_rsp,
    output logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_req_ack,
    input  logic              mem_rsp,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t           state, state_nxt;
    req_id_t          last, grant, gid;
    logic [CNT_W-1:0] cnt;
    logic             grant_now;
    logic             complete;
    logic             timed_out;

    rr_arb2 u_rr (
        .req   ({d_req, i_req}),
        .last  (last),
        .grant (grant)
    );

    // The counter reads TIMEOUT-1 during the last permitted wait cycle, so
    // the wait lasts exactly TIMEOUT cycles before the error is raised.
    always_comb begin
        grant_now = (state == IDLE) && (i_req || d_req);
        complete  = ((state == ISSUE) && mem_req_ack && mem_rsp) ||
                    ((state == WAIT_RSP) && mem_rsp);
        timed_out = (state == WAIT_RSP) && !mem_rsp &&
                    (cnt == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (grant_now) state_nxt = ISSUE;
            ISSUE:    if (mem_req_ack) state_nxt = mem_rsp ? IDLE : WAIT_RSP;
            WAIT_RSP: if (mem_rsp || timed_out) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last      <= REQ_I;
            gid       <= REQ_I;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            i_req_ack <= 1'b0;
            d_req_ack <= 1'b0;
            i_rsp     <= 1'b0;
            d_rsp     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            if (grant_now) begin
                gid       <= grant;
                last      <= grant;
                mem_addr  <= (grant == REQ_D) ? d_addr : i_addr;
                mem_we    <= (grant == REQ_D) ? d_we : 1'b0;
                mem_wdata <= (grant == REQ_D) ? d_wdata : '0;
            end

            if (state == ISSUE && mem_req_ack && !mem_rsp) begin
                cnt <= '0;
            end else if (state == WAIT_RSP) begin
                cnt <= cnt + 1'b1;
            end

            i_req_ack <= grant_now && (grant == REQ_I);
            d_req_ack <= grant_now && (grant == REQ_D);
            i_rsp     <= (complete || timed_out) && (gid == REQ_I);
            d_rsp     <= (complete || timed_out) && (gid == REQ_D);
            // rdata is zero except alongside a real completion.
            i_rdata   <= (complete && gid == REQ_I) ? mem_rdata : '0;
            d_rdata   <= (complete && gid == REQ_D) ? mem_rdata : '0;
            err       <= timed_out;
        end
    end

    assign mem_req = (state == ISSUE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for a memory response (legal range 1..65535).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-006 SHALL have ports i_req/d_req, input, 1, instruction-side and data-side request.
REQ-007 SHALL have ports i_addr/d_addr, input, ADDR_W, request address.
REQ-008 SHALL have port d_we, input, 1, data-side write enable (instruction side is read-only).
REQ-009 SHALL have port d_wdata, input, DATA_W, data-side write data.
REQ-010 SHALL have ports i_req_ack/d_req_ack, output, 1, one-cycle request-accepted pulse.
REQ-011 SHALL have ports i_rsp/d_rsp, output, 1, one-cycle response-valid pulse.
REQ-012 SHALL have ports i_rdata/d_rdata, output, DATA_W, response data, valid only with the matching rsp.
REQ-013 SHALL have port err, output, 1, one-cycle timeout pulse.
REQ-014 SHALL have ports mem_req (1), mem_addr (ADDR_W), mem_we (1), mem_wdata (DATA_W), all outputs, shared memory request.
REQ-015 SHALL have ports mem_req_ack (1), mem_rsp (1), mem_rdata (DATA_W), all inputs, memory accept, response and read data.

Function
REQ-016 SHALL implement an FSM with states IDLE, ISSUE and WAIT_RSP, allowing at most one outstanding memory transaction.
REQ-017 In IDLE with exactly one request high, the arbiter SHALL grant that requester.
REQ-018 In IDLE with both requests high, the arbiter SHALL grant the requester not granted last (round-robin); the last-granted flag resets to "inst", so data wins the first tie.
REQ-019 On grant, the arbiter SHALL latch the address, we and wdata (i-side: we=0, wdata=0), pulse the granted *_req_ack in the next cycle, and enter ISSUE.
REQ-020 Requesters SHALL hold req and payload until req_ack; req is sampled only in IDLE, and a req dropped before grant is ignored.
REQ-021 In ISSUE, the arbiter SHALL drive mem_req=1 with the latched payload, held stable until the cycle mem_req_ack=1.
REQ-022 After mem_req_ack: if mem_rsp=0, go to WAIT_RSP; if mem_rsp=1 in the same cycle, complete directly to IDLE.
REQ-023 In WAIT_RSP, on mem_rsp=1 the arbiter SHALL go to IDLE.
REQ-024 On completion, the arbiter SHALL register mem_rdata to the granted *_rdata and pulse the granted *_rsp one cycle after mem_rsp (fixed latency 1); the other side stays 0.
REQ-025 A 16-bit wait counter SHALL clear on WAIT_RSP entry and increment each cycle; when it reaches TIMEOUT without mem_rsp, the arbiter SHALL pulse err and the granted *_rsp with rdata=0, then return to IDLE.
REQ-026 mem_rsp or mem_req_ack arriving outside the matching state SHALL be ignored.
REQ-027 A new grant SHALL be possible in the cycle after return to IDLE; minimum turnaround is 3 cycles per transaction.
REQ-028 The *_req_ack, *_rsp and err pulses SHALL never be asserted for both sides simultaneously.

Reset
REQ-029 Asserting reset (0) SHALL immediately force IDLE, clear the counter, set last-granted=inst, and drive all outputs to 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no rsp or err pulse; a late mem_rsp after reset deassertion is ignored per REQ-026.
REQ-031 The first grant after reset deassertion SHALL be possible in the first rising edge at which reset=1.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT_RSP), the requester-id enum (REQ_I/REQ_D) and the counter width constant.
REQ-033 The two-input round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last; output grant id); all else is inline.

Verification
REQ-034 i_req with i_addr=0x100, mem_req_ack at 1 cycle, mem_rsp with rdata=0xDEADBEEF 2 cycles later -> mem_addr=0x100, mem_we=0; i_rsp pulses once with i_rdata=0xDEADBEEF.
REQ-035 i_req and d_req both high after reset (d_we=1, addr 0x200, wdata 0x55) -> data granted first with mem_we=1 and mem_wdata=0x55; inst is granted next; on a further tie, data wins again.
REQ-036 mem_req_ack held low 10 cycles -> mem_req and payload stay stable all 10 cycles; no req_ack re-pulse.
REQ-037 mem_req_ack and mem_rsp both high in the same cycle -> rsp one cycle later; FSM back to IDLE without visiting WAIT_RSP.
REQ-038 TIMEOUT=4 with mem_rsp never arriving -> err and d_rsp pulse after 4 WAIT_RSP cycles, d_rdata=0; the next request is served normally.
REQ-039 Reset asserted in WAIT_RSP, then mem_rsp after release -> no rsp or err; all outputs 0 during reset.
